// File: rtl/sensor_ctrl_pkg.sv
// Shared types for the sensor sequencer: FSM states, sizes and the round-robin picker.
// No latency or backpressure of its own; pure declarations and a combinational helper.
package sensor_ctrl_pkg;

    localparam int NUM_SENSORS = 4;
    localparam int CODE_W      = 2;

    typedef enum logic [2:0] {
        IDLE,
        SNAP,
        ARB,
        ADD,
        WAIT
    } state_t;

    typedef struct packed {
        logic              found;
        logic [CODE_W-1:0] idx;
    } pick_t;

    // First set bit at or above ptr, wrapping 3->0; scanned high-offset first so the nearest wins.
    function automatic pick_t rr_pick(input logic [NUM_SENSORS-1:0] snapshot,
                                      input logic [CODE_W-1:0]      ptr);
        pick_t             res;
        logic [CODE_W-1:0] cand;
        res = '0;
        for (int i = NUM_SENSORS - 1; i >= 0; i--) begin
            cand = ptr + CODE_W'(i);
            if (snapshot[cand]) begin
                res.found = 1'b1;
                res.idx   = cand;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/pulsador_debounce.sv
// Push-button conditioner: 2-flop synchronizer, debounce counter, rising-edge pulse.
// Latency: pulse appears DEBOUNCE_CYCLES+2 cycles after a clean raw edge; no backpressure.
module pulsador_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic start_pulse
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic             pulse_q;
    logic             pulse_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Counter tracks consecutive samples that disagree with the accepted level.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        pulse_d = level_d & ~level_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign start_pulse = pulse_q;

endmodule

// File: rtl/sensor_accum_ctrl.sv
// Sequencer: debounced press snapshots sensors, serves each set bit round-robin (3 cycles each), drives motor with min on-time.
// Presses while busy are dropped; ACC_SAT_GUARD_EN suppresses overflowing accumulator loads and raises sticky sat_flag.
module sensor_accum_ctrl
    import sensor_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = 16,
    parameter int MOTOR_HOLD_CYCLES = 50
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   boton,
    input  logic [NUM_SENSORS-1:0] sensores,
    input  logic [CODE_W-1:0]      acc_value,
    output logic [CODE_W-1:0]      code_out,
    output logic [NUM_SENSORS-1:0] grant,
    output logic                   acc_en,
    output logic                   busy,
    output logic                   motor_on,
    output logic                   sat_flag
);

    localparam int HOLD_W = (MOTOR_HOLD_CYCLES > 1) ? $clog2(MOTOR_HOLD_CYCLES) : 1;

    logic                   start_pulse;
    logic                   start_accept;
    state_t                 state_q;
    state_t                 state_d;
    logic [NUM_SENSORS-1:0] snap_q;
    logic [NUM_SENSORS-1:0] snap_d;
    logic [CODE_W-1:0]      ptr_q;
    logic [CODE_W-1:0]      ptr_d;
    logic [CODE_W-1:0]      gidx_q;
    logic [CODE_W-1:0]      gidx_d;
    logic [CODE_W-1:0]      cur_idx;
    logic                   in_scan;
    logic                   over;
    pick_t                  pick;

    logic                   demand;
    logic                   demand_q;
    logic                   motor_q;
    logic                   motor_d;
    logic [HOLD_W-1:0]      hold_q;
    logic [HOLD_W-1:0]      hold_d;

    pulsador_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk        (clk),
        .reset      (reset),
        .raw        (boton),
        .start_pulse(start_pulse)
    );

    assign start_accept = start_pulse && (state_q == IDLE);
    assign pick         = rr_pick(snap_q, ptr_q);

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        case (state_q)
            IDLE: begin
                if (start_pulse) begin
                    state_d = SNAP;
                end
            end
            SNAP: begin
                snap_d  = sensores;
                state_d = (|sensores) ? ARB : IDLE;
            end
            ARB: begin
                gidx_d  = pick.idx;
                state_d = ADD;
            end
            ADD: begin
                state_d = WAIT;
            end
            WAIT: begin
                snap_d  = snap_q & ~(NUM_SENSORS'(1) << gidx_q);
                ptr_d   = gidx_q + 1'b1;
                state_d = (|snap_d) ? ARB : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            snap_q  <= '0;
            ptr_q   <= '0;
            gidx_q  <= '0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
        end
    end

    // In ARB the pick is live; ADD and WAIT hold the registered index.
    assign in_scan  = (state_q == ARB) || (state_q == ADD) || (state_q == WAIT);
    assign cur_idx  = (state_q == ARB) ? pick.idx : gidx_q;
    assign code_out = in_scan ? cur_idx : '0;
    assign grant    = in_scan ? (NUM_SENSORS'(1) << cur_idx) : '0;
    assign busy     = (state_q != IDLE);

`ifdef ACC_SAT_GUARD_EN
    logic [CODE_W:0] sum;
    logic            sat_q;

    assign sum  = {1'b0, acc_value} + {1'b0, code_out};
    assign over = (state_q == ADD) && (sum > 3'd3);

    always_ff @(posedge clk) begin
        if (!reset) begin
            sat_q <= 1'b0;
        end else if (start_accept) begin
            sat_q <= 1'b0;
        end else if (over) begin
            sat_q <= 1'b1;
        end
    end

    assign sat_flag = sat_q;
`else
    logic unused_guard;

    assign over         = 1'b0;
    assign sat_flag     = 1'b0;
    assign unused_guard = acc_value[1] ^ start_accept;
`endif

    // Reset gates the strobe combinationally so a scan caught mid-ADD never loads.
    assign acc_en = (state_q == ADD) && reset && !over;

    assign demand = acc_value[0];

    always_comb begin
        motor_d = motor_q;
        hold_d  = hold_q;
        if (!motor_q) begin
            if (demand && !demand_q) begin
                motor_d = 1'b1;
                hold_d  = HOLD_W'(MOTOR_HOLD_CYCLES - 1);
            end
        end else if (hold_q != '0) begin
            hold_d = hold_q - 1'b1;
        end else if (!demand) begin
            motor_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            demand_q <= 1'b0;
            motor_q  <= 1'b0;
            hold_q   <= '0;
        end else begin
            demand_q <= demand;
            motor_q  <= motor_d;
            hold_q   <= hold_d;
        end
    end

    assign motor_on = motor_q;

endmodule

// File: tb/tb_sensor_accum_ctrl.sv
// Directed bench for sensor_accum_ctrl with a short debounce so presses fit inside scans.
module tb_sensor_accum_ctrl;

    localparam int DEB  = 4;
    localparam int HOLD = 50;

    logic       clk = 1'b0;
    logic       reset;
    logic       boton;
    logic [3:0] sensores;
    logic [1:0] acc_value;
    logic [1:0] code_out;
    logic [3:0] grant;
    logic       acc_en;
    logic       busy;
    logic       motor_on;
    logic       sat_flag;

    int n_cmp = 0;
    int n_bad = 0;

    int         acc_cnt  = 0;
    int         rise_cnt = 0;
    int         cyc      = 0;
    logic       busy_prev = 1'b0;
    logic [3:0] g_log [0:63];
    logic [1:0] c_log [0:63];
    int         t_log [0:63];

    sensor_accum_ctrl #(
        .DEBOUNCE_CYCLES  (DEB),
        .MOTOR_HOLD_CYCLES(HOLD)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .boton    (boton),
        .sensores (sensores),
        .acc_value(acc_value),
        .code_out (code_out),
        .grant    (grant),
        .acc_en   (acc_en),
        .busy     (busy),
        .motor_on (motor_on),
        .sat_flag (sat_flag)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc++;
        if (acc_en === 1'b1) begin
            if (acc_cnt < 64) begin
                g_log[acc_cnt] = grant;
                c_log[acc_cnt] = code_out;
                t_log[acc_cnt] = cyc;
            end
            acc_cnt++;
        end
        if (busy === 1'b1 && busy_prev !== 1'b1) rise_cnt++;
        busy_prev = busy;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (busy === 1'b0) break;
        end
        if (k == 200) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_idle: busy=%b still high after 200 cycles, required 0", busy);
        end
    endtask

    // Clean press; sensores switches to s_after once the snapshot has been taken.
    task automatic do_press(input logic [3:0] s_snap, input logic [3:0] s_after);
        int k;
        sensores = s_snap;
        boton    = 1'b1;
        for (k = 0; k < 40; k++) begin
            @(negedge clk);
            if (busy === 1'b1) break;
        end
        if (k == 40) begin
            n_cmp++; n_bad++;
            $display("FAIL press_start: busy=%b never rose, required 1", busy);
        end
        @(negedge clk);
        sensores = s_after;
        tick(DEB + 4);
        boton = 1'b0;
        wait_idle();
        tick(DEB + 6);
    endtask

    task automatic test_reset();
        reset = 1'b0; boton = 1'b0; sensores = 4'b0000; acc_value = 2'b00;
        tick(3);
        n_cmp++;
        if ({busy, grant, code_out, acc_en, motor_on, sat_flag} !== 10'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b, required all zero",
                     {busy, grant, code_out, acc_en, motor_on, sat_flag});
        end
        reset = 1'b1;
        tick(10);
    endtask

    task automatic test_empty_press();
        int n, a0, r0;
        a0 = acc_cnt; r0 = rise_cnt;
        sensores = 4'b0000;
        boton = 1'b1;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); n++;
            @(negedge clk);
            if (busy === 1'b1) break;
        end
        n_cmp++;
        if (n !== DEB + 3) begin
            n_bad++; $display("FAIL empty_latency: busy after %0d edges, required %0d", n, DEB + 3);
        end
        n_cmp++;
        if ({grant, code_out} !== 6'b0) begin
            n_bad++; $display("FAIL empty_snap_outputs: got %b, required 0", {grant, code_out});
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL empty_snap_only: busy=%b, required 0", busy);
        end
        tick(DEB);
        boton = 1'b0;
        tick(DEB + 6);
        n_cmp++;
        if ((acc_cnt - a0) !== 0 || (rise_cnt - r0) !== 1) begin
            n_bad++; $display("FAIL empty_counts: acc_en=%0d scans=%0d, required 0 and 1",
                              acc_cnt - a0, rise_cnt - r0);
        end
    endtask

    task automatic test_scan_1010();
        int a0;
        a0 = acc_cnt;
        do_press(4'b1010, 4'b1010);
        n_cmp++;
        if ((acc_cnt - a0) !== 2) begin
            n_bad++; $display("FAIL scan1010_count: got %0d acc_en, required 2", acc_cnt - a0);
        end
        n_cmp++;
        if (g_log[a0] !== 4'b0010 || c_log[a0] !== 2'b01) begin
            n_bad++; $display("FAIL scan1010_first: grant=%b code=%b, required 0010/01", g_log[a0], c_log[a0]);
        end
        n_cmp++;
        if (g_log[a0+1] !== 4'b1000 || c_log[a0+1] !== 2'b11) begin
            n_bad++; $display("FAIL scan1010_second: grant=%b code=%b, required 1000/11",
                              g_log[a0+1], c_log[a0+1]);
        end
        n_cmp++;
        if ((t_log[a0+1] - t_log[a0]) !== 3) begin
            n_bad++; $display("FAIL scan1010_spacing: %0d cycles, required 3", t_log[a0+1] - t_log[a0]);
        end
        n_cmp++;
        if ({busy, grant, code_out} !== 7'b0) begin
            n_bad++; $display("FAIL scan1010_idle: got %b, required 0", {busy, grant, code_out});
        end
    endtask

    task automatic test_ptr_wrap();
        int a0;
        logic [3:0] exp_g [0:2];
        logic [1:0] exp_c [0:2];
        exp_g[0] = 4'b1000; exp_g[1] = 4'b0001; exp_g[2] = 4'b0010;
        exp_c[0] = 2'b11;   exp_c[1] = 2'b00;   exp_c[2] = 2'b01;
        do_press(4'b0010, 4'b0010);
        a0 = acc_cnt;
        do_press(4'b1011, 4'b0100);
        n_cmp++;
        if ((acc_cnt - a0) !== 3) begin
            n_bad++; $display("FAIL wrap_count: got %0d acc_en, required 3", acc_cnt - a0);
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (g_log[a0+i] !== exp_g[i] || c_log[a0+i] !== exp_c[i]) begin
                n_bad++; $display("FAIL wrap_grant%0d: grant=%b code=%b, required %b/%b",
                                  i, g_log[a0+i], c_log[a0+i], exp_g[i], exp_c[i]);
            end
        end
    endtask

    task automatic test_bounce();
        int n, r0;
        r0 = rise_cnt;
        sensores = 4'b0000;
        boton = 1'b0;
        for (int i = 0; i < 12; i++) begin
            boton = ~boton;
            tick(3);
        end
        n_cmp++;
        if ((rise_cnt - r0) !== 0) begin
            n_bad++; $display("FAIL bounce_reject: %0d starts during bounce, required 0", rise_cnt - r0);
        end
        boton = 1'b1;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); n++;
            @(negedge clk);
            if (busy === 1'b1) break;
        end
        n_cmp++;
        if (n !== DEB + 3) begin
            n_bad++; $display("FAIL bounce_latency: busy after %0d edges, required %0d", n, DEB + 3);
        end
        tick(DEB + 4);
        boton = 1'b0;
        tick(DEB + 6);
        n_cmp++;
        if ((rise_cnt - r0) !== 1) begin
            n_bad++; $display("FAIL bounce_single: %0d starts, required 1", rise_cnt - r0);
        end
    endtask

    task automatic test_motor_and_drop();
        int hi, a0, r0;
        n_cmp++;
        if (motor_on !== 1'b0) begin
            n_bad++; $display("FAIL motor_idle: motor_on=%b, required 0", motor_on);
        end
        acc_value = 2'b01;
        @(negedge clk);
        acc_value = 2'b00;
        hi = (motor_on === 1'b1) ? 1 : 0;
        for (int i = 0; i < 79; i++) begin
            @(negedge clk);
            if (motor_on === 1'b1) hi++;
        end
        n_cmp++;
        if (hi !== HOLD) begin
            n_bad++; $display("FAIL motor_hold: high %0d cycles, required %0d", hi, HOLD);
        end
        // Second accepted level rise lands mid-scan and must vanish.
        a0 = acc_cnt; r0 = rise_cnt;
        sensores = 4'b1111;
        boton = 1'b1; tick(4);
        boton = 1'b0; tick(4);
        boton = 1'b1; tick(12);
        boton = 1'b0;
        wait_idle();
        tick(DEB + 10);
        n_cmp++;
        if ((acc_cnt - a0) !== 4 || (rise_cnt - r0) !== 1) begin
            n_bad++; $display("FAIL drop_press: acc_en=%0d scans=%0d, required 4 and 1",
                              acc_cnt - a0, rise_cnt - r0);
        end
    endtask

    task automatic test_reset_mid_scan();
        int a0;
        logic found;
        found = 1'b0;
        sensores = 4'b1111;
        acc_value = 2'b01;
        tick(2);
        boton = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (acc_en === 1'b1) begin found = 1'b1; break; end
        end
        n_cmp++;
        if (!found) begin
            n_bad++; $display("FAIL rst_mid_find: acc_en=%b never seen, required 1", acc_en);
        end
        reset = 1'b0;
        boton = 1'b0;
        #1;
        n_cmp++;
        if (acc_en !== 1'b0) begin
            n_bad++; $display("FAIL rst_mid_gate: acc_en=%b in reset cycle, required 0", acc_en);
        end
        @(posedge clk); #1;
        a0 = acc_cnt;
        n_cmp++;
        if ({busy, grant, code_out, acc_en, motor_on} !== 9'b0) begin
            n_bad++; $display("FAIL rst_mid_outputs: got %b, required 0",
                              {busy, grant, code_out, acc_en, motor_on});
        end
        @(negedge clk);
        acc_value = 2'b00;
        reset = 1'b1;
        tick(20);
        n_cmp++;
        if ((acc_cnt - a0) !== 0) begin
            n_bad++; $display("FAIL rst_mid_quiet: %0d acc_en after reset, required 0", acc_cnt - a0);
        end
        a0 = acc_cnt;
        do_press(4'b1111, 4'b1111);
        n_cmp++;
        if ((acc_cnt - a0) !== 4 || g_log[a0] !== 4'b0001) begin
            n_bad++; $display("FAIL rst_mid_ptr: count=%0d first grant=%b, required 4 and 0001",
                              acc_cnt - a0, g_log[a0]);
        end
    endtask

    task automatic test_sat();
        int a0;
        a0 = acc_cnt;
        acc_value = 2'b10;
        do_press(4'b1000, 4'b1000);
`ifdef ACC_SAT_GUARD_EN
        n_cmp++;
        if ((acc_cnt - a0) !== 0 || sat_flag !== 1'b1) begin
            n_bad++; $display("FAIL sat_guard: acc_en=%0d sat_flag=%b, required 0 and 1", acc_cnt - a0, sat_flag);
        end
        acc_value = 2'b00;
        do_press(4'b0000, 4'b0000);
        n_cmp++;
        if (sat_flag !== 1'b0) begin
            n_bad++; $display("FAIL sat_clear: sat_flag=%b after press, required 0", sat_flag);
        end
`else
        n_cmp++;
        if ((acc_cnt - a0) !== 1 || sat_flag !== 1'b0) begin
            n_bad++; $display("FAIL sat_off: acc_en=%0d sat_flag=%b, required 1 and 0", acc_cnt - a0, sat_flag);
        end
        acc_value = 2'b00;
`endif
    endtask

    initial begin
        test_reset();
        test_empty_press();
        test_scan_1010();
        test_ptr_wrap();
        test_bounce();
        test_motor_and_drop();
        test_reset_mid_scan();
        test_sat();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
